mul_rs: RTL and testbench
=========================

# mul_rs

Multiply reservation station for the Tomasulo core. It holds multiply instructions issued by the decode/issue stage and snoops the common data bus (CDB) until both operands are present. It dispatches one ready entry at a time into the multiply state/ALU pair (`mfState`/`mfALU`) and tags the multiplier's answer so the CDB arbiter can broadcast it and free the entry.

## Interface
Parameters:
- `ENTRIES`, 3: number of station entries (1..8).
- `TAG_W`, 4: tag width; tag value 0 means "operand value present".
- `TAG_BASE`, 4: tag of entry 0; entry i owns tag `TAG_BASE+i` (never 0).

Ports:
- `clk` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `issueEN` in 1: issue request, one instruction per cycle.
- `issueOp` in 2: multiply op code, carried to the unit unchanged.
- `issueV1`, `issueV2` in 32: operand values, valid when the matching Q is 0.
- `issueQ1`, `issueQ2` in TAG_W: producer tags, 0 = value present.
- `issueTag` out TAG_W: tag the entry will receive this cycle; 0 when full.
- `full` out 1: no FREE entry; issue is ignored when high.
- `cdbValid` in 1, `cdbTag` in TAG_W, `cdbData` in 32: CDB broadcast.
- `aluWEN` out 1: dispatch strobe, wired to `mfState.WEN`.
- `aluAvailable` in 1: from `mfState.available`.
- `aluOp` out 2, `aluData1`, `aluData2` out 32: operands of the dispatched entry.
- `aluRequire` in 1: from `mfState.require`; the result is on `mfALU.result`.
- `resultValid` out 1, `resultTag` out TAG_W: result request toward the CDB arbiter.
- `resultAC` in 1: arbiter grant, forwarded by top level to `mfState.requireAC`.

## Operation
- Per-entry state: FREE, WAIT, READY, EXEC. Per-entry fields: op, V1, Q1, V2, Q2.
- Issue: lowest-index FREE entry is allocated. `issueTag` = its tag. The entry goes to WAIT if any Q≠0 after forwarding, otherwise READY.
- Issue-time forwarding: if `cdbValid` and `cdbTag` equals `issueQx`≠0, store `cdbData` with Q=0.
- CDB snoop, WAIT entries: any Q equal to `cdbTag` (with `cdbValid`) captures `cdbData` and clears Q. The entry moves WAIT→READY on the edge at which its last Q clears.
- Dispatch select: lowest-index READY entry, from registered state.
  - `aluWEN` = `aluAvailable` AND any READY.
  - `aluOp`/`aluData*` come combinationally from the selected entry; they are 0 when none is selected.
  - On the edge with `aluWEN`: selected entry READY→EXEC, and `inflightTag` ← its tag.
- The unit holds at most one operation in flight, so exactly zero or one entry is in EXEC.
- Result: `resultValid` = `aluRequire`; `resultTag` = `inflightTag`.
  - On `resultAC` with `resultValid`, the EXEC entry goes to FREE.
  - Its own broadcast on the CDB is snooped like any other tag.
- Simultaneous events:
  - `resultAC` and `aluWEN` in the same cycle: old entry is freed, new entry enters EXEC, and `inflightTag` takes the new tag.
  - An entry freed this cycle is not visible to issue until the next cycle (`full` uses registered state).
  - An issue and a CDB match on a different entry in the same cycle are both applied.
- `resultAC` without `resultValid` is ignored.

## Timing
- Reset (edge with `RST`=1): all entries FREE, fields 0, `inflightTag`=0.
  - Resulting outputs: `full`=0, `issueTag`=`TAG_BASE`, `aluWEN`=0, `aluData*`=0, `aluOp`=0, `resultValid` follows `aluRequire`.
- Reset mid-operation discards every entry, including EXEC. The top level resets `mfState` on the same reset.
- Minimum issue→dispatch with both operands present: issue at edge N, `aluWEN` high in cycle N+1 if `aluAvailable`.
- Operand arrival on CDB at edge N: the entry is dispatchable in cycle N+1.
- `full`, `issueTag`, `aluWEN` and `aluData*` are combinational from registered state plus the `aluAvailable` input. There are no combinational paths from `cdb*` or `issue*`.

## Structure
- Shared package/header: the entry state encodings (FREE/WAIT/READY/EXEC) and the null tag 0.
- One sub-module, `mul_rs_entry`: a single entry holding its state, fields, CDB compare and issue capture. It exports ready/free flags and its fields.
- The parent holds the priority encoders (free and ready), `inflightTag`, and the output muxing.

## Test plan
- Reset, then issue V1=3, V2=5, Q1=Q2=0 with `aluAvailable`=1 → `issueTag`=4; next cycle `aluWEN`=1 with `aluData1`=3 and `aluData2`=5.
- Continue that operation: `aluRequire` high → `resultValid`=1, `resultTag`=4; with `resultAC`=1, entry 0 becomes FREE the next cycle.
- Issue Q1=9, V2=7, then CDB (9, 0x10) two cycles later → no dispatch before the broadcast; `aluWEN` the cycle after, with `aluData1`=0x10.
- Issue with Q2=6 in the same cycle as CDB (6, 0x22) → entry READY immediately; dispatched next cycle with `aluData2`=0x22.
- Fill all 3 entries while `aluAvailable`=0 → `full`=1, `issueTag`=0, and a 4th issue is ignored. Then raise `aluAvailable` → entries dispatch in index order 0, 1, 2, one per completed result.
- `resultAC` with a READY entry pending and `aluAvailable`=1 → same-cycle free of the old tag and dispatch of the new one; `resultTag` changes to the new tag.

Source files
------------

// File: rtl/mul_rs_pkg.sv
// Shared definitions for the multiply reservation station: entry states,
// datapath widths and the null tag that marks an operand value as present.
package mul_rs_pkg;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 2;
  localparam int NULL_TAG = 0;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } ent_state_e;
endpackage

// File: rtl/mul_rs_if.sv
// Issue, CDB, multiplier-dispatch and result-request signals of the multiply
// reservation station; slave is the station side, master the surrounding core.
interface mul_rs_if #(parameter int TAG_W = 4);
  import mul_rs_pkg::*;

  logic              issueEN;
  logic [OP_W-1:0]   issueOp;
  logic [DATA_W-1:0] issueV1;
  logic [DATA_W-1:0] issueV2;
  logic [TAG_W-1:0]  issueQ1;
  logic [TAG_W-1:0]  issueQ2;
  logic [TAG_W-1:0]  issueTag;
  logic              full;
  logic              cdbValid;
  logic [TAG_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;
  logic              aluWEN;
  logic              aluAvailable;
  logic [OP_W-1:0]   aluOp;
  logic [DATA_W-1:0] aluData1;
  logic [DATA_W-1:0] aluData2;
  logic              aluRequire;
  logic              resultValid;
  logic [TAG_W-1:0]  resultTag;
  logic              resultAC;

  modport slave (
    input  issueEN, issueOp, issueV1, issueV2, issueQ1, issueQ2,
    output issueTag, full,
    input  cdbValid, cdbTag, cdbData,
    output aluWEN, aluOp, aluData1, aluData2,
    input  aluAvailable, aluRequire,
    output resultValid, resultTag,
    input  resultAC
  );

  modport master (
    output issueEN, issueOp, issueV1, issueV2, issueQ1, issueQ2,
    input  issueTag, full,
    output cdbValid, cdbTag, cdbData,
    input  aluWEN, aluOp, aluData1, aluData2,
    output aluAvailable, aluRequire,
    input  resultValid, resultTag,
    output resultAC
  );
endinterface

// File: rtl/mul_rs_entry.sv
// One reservation-station entry: lifecycle state, operand fields, issue-time
// capture with CDB forwarding, and CDB snooping while waiting for operands.
module mul_rs_entry
  import mul_rs_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] v1_i,
  input  logic [DATA_W-1:0] v2_i,
  input  logic [TAG_W-1:0]  q1_i,
  input  logic [TAG_W-1:0]  q2_i,
  input  logic              cdb_vld_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  input  logic              dispatch_i,
  input  logic              release_i,
  output logic              free_o,
  output logic              ready_o,
  output logic              exec_o,
  output logic [OP_W-1:0]   op_o,
  output logic [DATA_W-1:0] v1_o,
  output logic [DATA_W-1:0] v2_o
);
  localparam logic [TAG_W-1:0] NULL_Q = TAG_W'(NULL_TAG);

  ent_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0]  q1_q, q1_d, q2_q, q2_d;

  // Operand capture: at allocation the incoming tags are compared against the
  // CDB so a same-cycle broadcast is not lost; afterwards only WAIT snoops.
  always_comb begin
    op_d = op_q;
    v1_d = v1_q;
    v2_d = v2_q;
    q1_d = q1_q;
    q2_d = q2_q;
    if (state_q == ST_FREE && alloc_i) begin
      op_d = op_i;
      if (cdb_vld_i && q1_i != NULL_Q && cdb_tag_i == q1_i) begin
        v1_d = cdb_data_i;
        q1_d = NULL_Q;
      end else begin
        v1_d = v1_i;
        q1_d = q1_i;
      end
      if (cdb_vld_i && q2_i != NULL_Q && cdb_tag_i == q2_i) begin
        v2_d = cdb_data_i;
        q2_d = NULL_Q;
      end else begin
        v2_d = v2_i;
        q2_d = q2_i;
      end
    end else if (state_q == ST_WAIT) begin
      if (cdb_vld_i && q1_q != NULL_Q && cdb_tag_i == q1_q) begin
        v1_d = cdb_data_i;
        q1_d = NULL_Q;
      end
      if (cdb_vld_i && q2_q != NULL_Q && cdb_tag_i == q2_q) begin
        v2_d = cdb_data_i;
        q2_d = NULL_Q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FREE:  if (alloc_i)
                  state_d = (q1_d != NULL_Q || q2_d != NULL_Q) ? ST_WAIT : ST_READY;
      ST_WAIT:  if (q1_d == NULL_Q && q2_d == NULL_Q) state_d = ST_READY;
      ST_READY: if (dispatch_i) state_d = ST_EXEC;
      ST_EXEC:  if (release_i) state_d = ST_FREE;
      default:  state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FREE;
      op_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
    end
  end

  always_comb begin
    free_o  = (state_q == ST_FREE);
    ready_o = (state_q == ST_READY);
    exec_o  = (state_q == ST_EXEC);
    op_o    = op_q;
    v1_o    = v1_q;
    v2_o    = v2_q;
  end
endmodule

// File: rtl/mul_rs.sv
// Multiply reservation station: allocates the lowest free entry on issue,
// dispatches the lowest ready entry to the multiplier and tags its result.
module mul_rs
  import mul_rs_pkg::*;
#(
  parameter int ENTRIES  = 3,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 4
) (
  input logic      clk,
  input logic      RST,
  mul_rs_if.slave  bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] free_v, ready_v, exec_v, alloc_v, disp_v, rel_v;
  logic [OP_W-1:0]    op_v [ENTRIES];
  logic [DATA_W-1:0]  v1_v [ENTRIES];
  logic [DATA_W-1:0]  v2_v [ENTRIES];

  logic              free_any, ready_any;
  logic [IDX_W-1:0]  free_idx, ready_idx;
  logic [TAG_W-1:0]  inflight_q, inflight_d;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    mul_rs_entry #(.TAG_W(TAG_W)) u_ent (
      .clk        (clk),
      .rst        (RST),
      .alloc_i    (alloc_v[g]),
      .op_i       (bus.issueOp),
      .v1_i       (bus.issueV1),
      .v2_i       (bus.issueV2),
      .q1_i       (bus.issueQ1),
      .q2_i       (bus.issueQ2),
      .cdb_vld_i  (bus.cdbValid),
      .cdb_tag_i  (bus.cdbTag),
      .cdb_data_i (bus.cdbData),
      .dispatch_i (disp_v[g]),
      .release_i  (rel_v[g]),
      .free_o     (free_v[g]),
      .ready_o    (ready_v[g]),
      .exec_o     (exec_v[g]),
      .op_o       (op_v[g]),
      .v1_o       (v1_v[g]),
      .v2_o       (v2_v[g])
    );
  end

  // Priority encoders scan from the top so the lowest index wins; both work
  // on registered entry state, so a slot freed this cycle is seen next cycle.
  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    ready_any = 1'b0;
    ready_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_v[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ready_v[i]) begin
        ready_any = 1'b1;
        ready_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    bus.full     = !free_any;
    bus.issueTag = free_any ? TAG_W'(TAG_BASE + int'(free_idx)) : '0;
    alloc_v      = '0;
    alloc_v[free_idx] = bus.issueEN && free_any;

    bus.aluWEN   = bus.aluAvailable && ready_any;
    disp_v       = '0;
    disp_v[ready_idx] = bus.aluWEN;
    bus.aluOp    = ready_any ? op_v[ready_idx] : '0;
    bus.aluData1 = ready_any ? v1_v[ready_idx] : '0;
    bus.aluData2 = ready_any ? v2_v[ready_idx] : '0;

    bus.resultValid = bus.aluRequire;
    bus.resultTag   = inflight_q;
    rel_v = exec_v & {ENTRIES{bus.aluRequire && bus.resultAC}};

    inflight_d = inflight_q;
    if (bus.aluWEN) inflight_d = TAG_W'(TAG_BASE + int'(ready_idx));
  end

  always_ff @(posedge clk) begin
    if (RST) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end
endmodule

// File: tb/tb_mul_rs.sv
// Directed bench for mul_rs: a cycle-by-cycle vector table plus a hand-written
// mid-operation reset sequence; the bench plays the role of mfState.
module tb_mul_rs;
  logic clk = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul_rs_if #(.TAG_W(4)) bus ();

  mul_rs #(.ENTRIES(3), .TAG_W(4), .TAG_BASE(4)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic [31:0] v1, v2;
    logic [3:0]  q1, q2;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        av, req, ac;
    logic        x_full;
    logic [3:0]  x_itag;
    logic        x_wen;
    logic [1:0]  x_op;
    logic [31:0] x_d1, x_d2;
    logic        x_rv;
    logic [3:0]  x_rtag;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int en, op, v1, v2, q1, q2, cv, ct, cd, av, req, ac,
                              input int full, itag, wen, aop, d1, d2, rv, rtag);
    vec_t r;
    r.en = en[0];   r.op = op[1:0];  r.v1 = v1;      r.v2 = v2;
    r.q1 = q1[3:0]; r.q2 = q2[3:0];  r.cv = cv[0];   r.ct = ct[3:0]; r.cd = cd;
    r.av = av[0];   r.req = req[0];  r.ac = ac[0];
    r.x_full = full[0]; r.x_itag = itag[3:0]; r.x_wen = wen[0]; r.x_op = aop[1:0];
    r.x_d1 = d1;    r.x_d2 = d2;     r.x_rv = rv[0]; r.x_rtag = rtag[3:0];
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic drive(input vec_t t);
    bus.issueEN = t.en;  bus.issueOp = t.op;  bus.issueV1 = t.v1;  bus.issueV2 = t.v2;
    bus.issueQ1 = t.q1;  bus.issueQ2 = t.q2;
    bus.cdbValid = t.cv; bus.cdbTag = t.ct;   bus.cdbData = t.cd;
    bus.aluAvailable = t.av; bus.aluRequire = t.req; bus.resultAC = t.ac;
  endtask

  task automatic check_out(input vec_t t, input string nm);
    chk({nm, ".full"},  32'(bus.full),        32'(t.x_full));
    chk({nm, ".itag"},  32'(bus.issueTag),    32'(t.x_itag));
    chk({nm, ".wen"},   32'(bus.aluWEN),      32'(t.x_wen));
    chk({nm, ".op"},    32'(bus.aluOp),       32'(t.x_op));
    chk({nm, ".d1"},    bus.aluData1,         t.x_d1);
    chk({nm, ".d2"},    bus.aluData2,         t.x_d2);
    chk({nm, ".rv"},    32'(bus.resultValid), 32'(t.x_rv));
    chk({nm, ".rtag"},  32'(bus.resultTag),   32'(t.x_rtag));
  endtask

  // Inputs are applied just after an edge, outputs checked mid-cycle, then
  // the next rising edge commits the cycle.
  task automatic apply(input vec_t t, input string nm);
    drive(t);
    #2;
    check_out(t, nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0,0);
    drive(idle);

    //        en op v1    v2    q1 q2  cv ct cd     av rq ac  full itag wen op d1     d2     rv rtag
    // reset state
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   0,4,0,0,0,0,0,0));
    // ready-at-issue operation, result handshake, ignored stray grant
    tbl.push_back(mk(1,1,3,5,0,0,      0,0,0,      1,0,0,   0,4,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   0,5,1,1,3,5,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,1,   0,5,0,0,0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,0,   0,5,0,0,0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,1,   0,5,0,0,0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   0,4,0,0,0,0,0,4));
    // waiting operand, wrong-tag broadcast, then matching broadcast with a
    // same-cycle issue into another entry
    tbl.push_back(mk(1,2,0,7,9,0,      0,0,0,      1,0,0,   0,4,0,0,0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,      1,8,'h99,   1,0,0,   0,5,0,0,0,0,0,4));
    tbl.push_back(mk(1,0,2,3,0,0,      1,9,'h10,   1,0,0,   0,5,0,0,0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   0,6,1,2,'h10,7,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,0,   0,6,0,0,2,3,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,1,1,   0,6,1,0,2,3,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,1,   0,4,0,0,0,0,1,5));
    // issue-time forwarding of Q2
    tbl.push_back(mk(1,3,'h11,0,0,6,   1,6,'h22,   1,0,0,   0,4,0,0,0,0,0,5));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   0,5,1,3,'h11,'h22,0,5));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,1,   0,5,0,0,0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,0,0,   0,4,0,0,0,0,0,4));
    // fill all entries, 4th issue ignored, drain in index order with
    // same-cycle free and dispatch
    tbl.push_back(mk(1,0,10,20,0,0,    0,0,0,      0,0,0,   0,4,0,0,0,0,0,4));
    tbl.push_back(mk(1,1,11,21,0,0,    0,0,0,      0,0,0,   0,5,0,0,10,20,0,4));
    tbl.push_back(mk(1,2,12,22,0,0,    0,0,0,      0,0,0,   0,6,0,0,10,20,0,4));
    tbl.push_back(mk(1,3,'h77,'h77,0,0,0,0,0,      0,0,0,   1,0,0,0,10,20,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   1,0,1,0,10,20,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,0,   1,0,0,1,11,21,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,1,1,   1,0,1,1,11,21,1,4));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,0,   0,4,0,2,12,22,1,5));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,1,1,   0,4,1,2,12,22,1,5));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   0,4,0,0,0,0,0,6));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      0,1,1,   0,4,0,0,0,0,1,6));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,      1,0,0,   0,4,0,0,0,0,0,6));

    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Reset while one entry executes and another is ready: both are discarded.
    apply(mk(1,1,5,6,0,0, 0,0,0, 0,0,0, 0,4,0,0,0,0,0,6), "rst.iss0");
    apply(mk(1,2,7,8,0,0, 0,0,0, 1,0,0, 0,5,1,1,5,6,0,6), "rst.iss1");
    drive(mk(0,0,0,0,0,0, 0,0,0, 1,1,0, 0,0,0,0,0,0,0,0));
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    #2;
    check_out(mk(0,0,0,0,0,0, 0,0,0, 1,1,0, 0,4,0,0,0,0,1,0), "rst.after");
    @(posedge clk);
    #1;
    apply(mk(0,0,0,0,0,0, 0,0,0, 1,0,0, 0,4,0,0,0,0,0,0), "rst.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
